// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and requantization helper for the fc neuron driver
package fc_pkg;

  localparam int FC_WIDTH = 8;
  localparam int FC_IN    = 128;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  // z is post-ReLU, so it is shifted as unsigned and clamped to width bits
  function automatic logic [31:0] sat_shift(input logic [63:0] z, input int shift, input int width);
    logic [63:0] v;
    v = z >> shift;
    if (v >= (64'd1 << width))
      return 32'((64'd1 << width) - 64'd1);
    return 32'(v);
  endfunction

endpackage

// File: rtl/act_bank.sv
// rtl/act_bank.sv - activation register file with indexed write and clear-all-but-index
module act_bank #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic                     i_clr_others,
  input  logic [$clog2(IN)-1:0]    i_idx,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_x [0:IN-1]
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) o_x[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < IN; i++) begin
        if (i_idx == ($clog2(IN))'(i))
          o_x[i] <= i_data;
        else if (i_clr_others)
          o_x[i] <= '0;
      end
    end
  end

endmodule

// File: rtl/fc_frame_driver.sv
// rtl/fc_frame_driver.sv - deserializes activations for one neuron layer and requantizes its result
module fc_frame_driver
  import fc_pkg::*;
#(
  parameter int WIDTH  = FC_WIDTH,
  parameter int IN     = FC_IN,
  parameter int ZW     = 2*WIDTH + $clog2(IN),
  parameter int SETTLE = 2,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WIDTH-1:0]  x_out [0:IN-1],
  input  logic [ZW-1:0]     z_in,
  output logic [ZW-1:0]     out_raw,
  output logic [WIDTH-1:0]  out_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int CW = $clog2(IN);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_settle;

  logic            w_acc;
  logic            w_at_end;
  logic            w_frame_end;
  logic [WIDTH-1:0] w_q;

  assign in_ready    = (r_state == ST_FILL);
  assign w_acc       = in_valid && in_ready;
  assign w_at_end    = (r_cnt == CW'(IN-1));
  assign w_frame_end = w_acc && (in_last || w_at_end);
  assign w_q         = WIDTH'(sat_shift(64'(z_in), SHIFT, WIDTH));

  act_bank #(.WIDTH(WIDTH), .IN(IN)) u_bank (
    .clk          (clk),
    .rst          (rst),
    .i_we         (w_acc),
    .i_clr_others (r_cnt == '0),
    .i_idx        (r_cnt),
    .i_data       (in_data),
    .o_x          (x_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FILL;
      r_cnt     <= '0;
      r_settle  <= '0;
      out_raw   <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_frame_end) begin
            r_cnt    <= '0;
            r_state  <= ST_SETTLE;
            r_settle <= 4'(SETTLE-1);
          end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // x_out is frozen here so the combinational tree sees a stable vector
        ST_SETTLE: begin
          if (r_settle == '0) begin
            out_raw   <= z_in;
            out_q     <= w_q;
            out_valid <= 1'b1;
            r_state   <= ST_OUT;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // a length error on the same cycle as a clear must survive
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_err <= 1'b0;
    else if (w_acc && (in_last != w_at_end))
      frame_err <= 1'b1;
    else if (err_clr)
      frame_err <= 1'b0;
  end

endmodule

// File: doc/fc_frame_driver.md
Name: fc_frame_driver

Overview:
- Sequential front/back end for one combinational fully-connected neuron `layer` (constant-weight booth multipliers, adder tree, ReLU).
- Deserializes an 8-bit activation stream into the IN-entry vector `x` that `layer` consumes.
- Holds that vector stable for a fixed settle window, captures the neuron result `z`, requantizes it to WIDTH bits and hands it downstream with valid/ready.
- One instance per neuron; this block is the producer of the layer's input and the consumer of its output.

Parameters:
- WIDTH, 8, activation bit width (same as `layer`).
- IN, 128, activations per frame.
- ZW, 2*WIDTH+$clog2(IN), width of `layer` output `z`.
- SETTLE, 2, cycles `x_out` is held stable before `z_in` is sampled (covers combinational tree delay as multicycle path); legal 1..15.
- SHIFT, 8, right-shift applied to `z_in` before saturation to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  activation beat.
- in_valid  input  1  beat valid.
- in_last  input  1  marks final beat of a frame.
- in_ready  output  1  block accepts beat.
- x_out  output  WIDTH x [0:IN-1] (unpacked)  activation bank driven to `layer.x`.
- z_in  input  ZW  `layer.z` (post-ReLU, non-negative).
- out_raw  output  ZW  captured `z_in`.
- out_q  output  WIDTH  requantized result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- frame_err  output  1  sticky: frame length != IN.
- err_clr  input  1  clears frame_err.

Behaviour:
- Reset values (async on rst high): state=FILL, beat count=0, all x_out entries=0, out_raw=0, out_q=0, out_valid=0, frame_err=0.
- in_ready = (state==FILL). Beat accepted when in_valid && in_ready.
- FILL state:
  - Each accepted beat writes in_data to x_out[cnt], then cnt++.
  - First accepted beat of a frame (cnt==0) zeroes entries 1..IN-1 in the same cycle and writes entry 0.
  - Frame ends on an accepted beat with in_last=1, or on accepted beat cnt==IN-1, whichever comes first.
  - Early last (cnt<IN-1 with in_last): frame_err<=1; unwritten entries stay 0.
  - Beat cnt==IN-1 without in_last: frame_err<=1; the frame still ends. The next beat starts a new frame.
  - On frame end: cnt<=0, state<=SETTLE, settle counter<=SETTLE-1.
- SETTLE state:
  - x_out frozen.
  - Counter decrements each cycle; at 0, capture out_raw<=z_in and out_q<=sat(z_in>>>SHIFT), then state<=OUT and out_valid<=1.
  - Latency from the frame-ending beat edge to out_valid high is SETTLE+1 cycles.
- Requantization sat(v): if v>=2^WIDTH then 2^WIDTH-1, else v[WIDTH-1:0]. z_in is treated as unsigned because it is post-ReLU.
- OUT state:
  - out_valid, out_raw and out_q are stable while out_ready=0.
  - On out_valid && out_ready: out_valid<=0, state<=FILL. in_ready is high from the next cycle; no bubble beyond that one.
  - x_out keeps its last frame until the next frame's first beat.
- frame_err: set has priority over err_clr when both occur in the same cycle.
- rst asserted mid-frame or mid-OUT: immediate return to reset values; the partial frame and pending result are discarded.
- in_valid while in_ready=0: ignored; the source must hold the beat.

Decomposition:
- Shared package `fc_pkg`:
  - state enum {FILL, SETTLE, OUT}.
  - function sat_shift(z, SHIFT) returning WIDTH bits.
  - Default constants WIDTH=8, IN=128.
- Sub-module `act_bank`: IN x WIDTH register file with indexed write and clear-all-but-index. `fc_frame_driver` instantiates `act_bank` and connects `layer` externally at the parent.

Test Plan:
- Reset: rst pulse mid-FILL after 40 beats -> in_ready=1, all x_out=0, out_valid=0; the next 128-beat frame completes normally.
- Normal frame: 128 beats of in_data=k mod 256, in_last on beat 127, bench drives z_in=23'd1000, SETTLE=2 -> out_valid rises exactly 3 cycles after beat 127, out_raw=1000, out_q=3, frame_err=0.
- Saturation: z_in=23'h10000 with SHIFT=8 -> out_q=255. z_in=0 -> out_q=0.
- Short frame: in_last on beat 9 (values 1..10) -> frame_err=1, x_out[0..9]=1..10, x_out[10..127]=0, result still produced. Then err_clr -> frame_err=0.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 -> out_valid and out_q stable, in_ready=0, no beats consumed. Raise out_ready -> handshake completes, in_ready=1 the next cycle.
- Missing last: 128 beats with no in_last -> frame_err=1, SETTLE entered after beat 127, and the following beat is x_out[0] of the next frame.
